dut_unpack: RTL and testbench

DUT_UNPACK -- requirements
Module: dut_unpack

---
 rtl/dut_unpack_if.sv | 71 +++++++
 rtl/dut_unpack.sv | 220 ++++++++++++++++++++++
 tb/tb_dut_unpack.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dut_unpack_if.sv
// -----------------------------------------------------------------------------
// dut_unpack_if
// Purpose : groups every non-clock/reset signal of the dut_unpack word
//           unpacker: configuration inputs, the packed-word input handshake,
//           the sample output handshake and the status outputs.
// Modports:
//   slave  - the unpacker itself (accepts packed words, produces samples)
//   master - the surrounding logic (offers packed words, consumes samples)
// Signals :
//   i_dut_unpack_capture_mode [2:0]  3'b000 single-channel, 3'b011 octal
//   i_dut_unpack_frame_len   [15:0]  words per frame, 0 = continuous
//   i_dut_unpack_word_valid          packed word offered
//   i_dut_unpack_word_data           packed word, lane 0 at LSBs (oldest)
//   o_dut_unpack_word_ready          packed word can be taken this cycle
//   o_dut_unpack_sample_valid        sample available
//   o_dut_unpack_sample_data         current sample
//   o_dut_unpack_sample_chan  [2:0]  channel tag of current sample
//   o_dut_unpack_sample_last         final sample of the frame
//   i_dut_unpack_sample_ready        sample consumed on valid && ready
//   o_dut_unpack_busy                unpacker is shifting out a word
//   o_dut_unpack_mode_err            sticky unsupported-mode flag
// -----------------------------------------------------------------------------
interface dut_unpack_if #(
  parameter int ADC_MAX_DATA_SIZE = 16,
  parameter int BRAM_WORD_NUM     = 16
);

  logic [2:0]                                 i_dut_unpack_capture_mode;
  logic [15:0]                                i_dut_unpack_frame_len;
  logic                                       i_dut_unpack_word_valid;
  logic [ADC_MAX_DATA_SIZE*BRAM_WORD_NUM-1:0] i_dut_unpack_word_data;
  logic                                       o_dut_unpack_word_ready;
  logic                                       o_dut_unpack_sample_valid;
  logic [ADC_MAX_DATA_SIZE-1:0]               o_dut_unpack_sample_data;
  logic [2:0]                                 o_dut_unpack_sample_chan;
  logic                                       o_dut_unpack_sample_last;
  logic                                       i_dut_unpack_sample_ready;
  logic                                       o_dut_unpack_busy;
  logic                                       o_dut_unpack_mode_err;

  modport slave (
    input  i_dut_unpack_capture_mode,
    input  i_dut_unpack_frame_len,
    input  i_dut_unpack_word_valid,
    input  i_dut_unpack_word_data,
    output o_dut_unpack_word_ready,
    output o_dut_unpack_sample_valid,
    output o_dut_unpack_sample_data,
    output o_dut_unpack_sample_chan,
    output o_dut_unpack_sample_last,
    input  i_dut_unpack_sample_ready,
    output o_dut_unpack_busy,
    output o_dut_unpack_mode_err
  );

  modport master (
    output i_dut_unpack_capture_mode,
    output i_dut_unpack_frame_len,
    output i_dut_unpack_word_valid,
    output i_dut_unpack_word_data,
    input  o_dut_unpack_word_ready,
    input  o_dut_unpack_sample_valid,
    input  o_dut_unpack_sample_data,
    input  o_dut_unpack_sample_chan,
    input  o_dut_unpack_sample_last,
    output i_dut_unpack_sample_ready,
    input  o_dut_unpack_busy,
    input  o_dut_unpack_mode_err
  );

endinterface

// File: rtl/dut_unpack.sv
// -----------------------------------------------------------------------------
// dut_unpack
// Purpose : unpacks wide BRAM words holding BRAM_WORD_NUM samples of
//           ADC_MAX_DATA_SIZE bits into a stream of single samples, one per
//           cycle while the consumer is ready. Lane 0 (LSBs) is sent first.
//           Each word is tagged with the capture mode present when it was
//           accepted: single-channel (chan always 0) or octal (chan cycles
//           0..7 with the lane index). Words offered in any other mode are
//           dropped and raise a sticky mode_err flag. A 16-bit word counter
//           marks the last sample of every frame of frame_len words
//           (frame_len = 0 means an endless stream with no last marker).
// Ports   :
//   i_dut_unpack_clk      clock, all logic on the rising edge
//   i_dut_unpack_reset_n  asynchronous active-low reset
//   bus                   dut_unpack_if.slave (handshakes, config, status)
// Build option:
//   DUT_UNPACK_BYTE_SWAP_EN  when defined, the upper and lower halves of every
//                            outgoing sample are exchanged (USB byte order);
//                            when undefined samples leave unmodified.
// -----------------------------------------------------------------------------
module dut_unpack #(
  parameter int ADC_MAX_DATA_SIZE = 16,
  parameter int BRAM_WORD_NUM     = 16
) (
  input  logic        i_dut_unpack_clk,
  input  logic        i_dut_unpack_reset_n,
  dut_unpack_if.slave bus
);

  localparam int WORD_W = ADC_MAX_DATA_SIZE * BRAM_WORD_NUM;
  localparam int IDX_W  = (BRAM_WORD_NUM > 1) ? $clog2(BRAM_WORD_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BRAM_WORD_NUM - 1);

  localparam logic [2:0] MODE_SINGLE = 3'b000;
  localparam logic [2:0] MODE_OCTAL  = 3'b011;

  typedef enum logic {
    EMPTY = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [WORD_W-1:0] holding;
  logic [IDX_W-1:0]  index;
  logic [15:0]       word_cnt;
  logic [2:0]        mode;
  logic              mode_err;

  logic mode_ok;
  logic at_last_lane;
  logic consume;
  logic word_done;
  logic word_accept;
  logic load_word;
  logic drop_word;
  logic frame_end;

  logic                         word_ready;
  logic                         sample_valid;
  logic [ADC_MAX_DATA_SIZE-1:0] sample_data;
  logic [2:0]                   sample_chan;
  logic                         sample_last;
  logic                         busy;

  logic [ADC_MAX_DATA_SIZE-1:0] lane_sample;
  logic [ADC_MAX_DATA_SIZE-1:0] out_sample;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign mode_ok = (bus.i_dut_unpack_capture_mode == MODE_SINGLE) ||
                   (bus.i_dut_unpack_capture_mode == MODE_OCTAL);

  assign at_last_lane = (index == LAST_IDX);

  // In SHIFT a sample is always on offer, so the consumer's ready alone
  // decides whether the current lane leaves this cycle.
  assign consume   = (state == SHIFT) && bus.i_dut_unpack_sample_ready;
  assign word_done = consume && at_last_lane;

  assign word_accept = bus.i_dut_unpack_word_valid && word_ready;
  assign load_word   = word_accept && mode_ok;
  assign drop_word   = word_accept && !mode_ok;

  // frame_len is compared live, so a new length applies from the next word
  // that reaches its final lane without disturbing the running count.
  assign frame_end = (bus.i_dut_unpack_frame_len != 16'd0) &&
                     (word_cnt == bus.i_dut_unpack_frame_len - 16'd1);

  // ---------------------------------------------------------------------------
  // Lane select and optional byte-order swap
  // ---------------------------------------------------------------------------
  assign lane_sample = holding[32'(index) * ADC_MAX_DATA_SIZE +: ADC_MAX_DATA_SIZE];

`ifdef DUT_UNPACK_BYTE_SWAP_EN
  localparam int HALF_W = ADC_MAX_DATA_SIZE / 2;
  assign out_sample = {lane_sample[HALF_W-1:0],
                       lane_sample[ADC_MAX_DATA_SIZE-1:HALF_W]};
`else
  assign out_sample = lane_sample;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_dut_unpack_clk or negedge i_dut_unpack_reset_n) begin
    if (!i_dut_unpack_reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // A new word loaded on the cycle the last lane leaves keeps the FSM in
  // SHIFT, giving a bubble-free stream across word boundaries.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (load_word) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (word_done) begin
          state_next = load_word ? SHIFT : EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // word_ready looks through to sample_ready on the final lane so the next
  // word can be taken in the same cycle the current one finishes.
  // ---------------------------------------------------------------------------
  always_comb begin
    word_ready   = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    sample_chan  = 3'd0;
    sample_last  = 1'b0;
    busy         = 1'b0;
    case (state)
      EMPTY: begin
        word_ready = 1'b1;
      end
      SHIFT: begin
        busy         = 1'b1;
        sample_valid = 1'b1;
        sample_data  = out_sample;
        sample_chan  = (mode == MODE_OCTAL) ? 3'(index) : 3'd0;
        sample_last  = at_last_lane && frame_end;
        word_ready   = at_last_lane && bus.i_dut_unpack_sample_ready;
      end
      default: begin
        word_ready = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Holding register, lane index and latched mode
  // The index returns to 0 when a word drains without a successor so that a
  // later word always starts from lane 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_dut_unpack_clk or negedge i_dut_unpack_reset_n) begin
    if (!i_dut_unpack_reset_n) begin
      holding <= '0;
      index   <= '0;
      mode    <= MODE_SINGLE;
    end else if (load_word) begin
      holding <= bus.i_dut_unpack_word_data;
      index   <= '0;
      mode    <= bus.i_dut_unpack_capture_mode;
    end else if (word_done) begin
      index <= '0;
    end else if (consume) begin
      index <= index + IDX_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame word counter: counts completed words, wraps after the frame's last
  // word, and free-runs through 16 bits when frame_len is 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_dut_unpack_clk or negedge i_dut_unpack_reset_n) begin
    if (!i_dut_unpack_reset_n) begin
      word_cnt <= 16'd0;
    end else if (word_done) begin
      word_cnt <= frame_end ? 16'd0 : word_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error for words offered in an unsupported capture mode
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_dut_unpack_clk or negedge i_dut_unpack_reset_n) begin
    if (!i_dut_unpack_reset_n) begin
      mode_err <= 1'b0;
    end else if (drop_word) begin
      mode_err <= 1'b1;
    end
  end

  assign bus.o_dut_unpack_word_ready   = word_ready;
  assign bus.o_dut_unpack_sample_valid = sample_valid;
  assign bus.o_dut_unpack_sample_data  = sample_data;
  assign bus.o_dut_unpack_sample_chan  = sample_chan;
  assign bus.o_dut_unpack_sample_last  = sample_last;
  assign bus.o_dut_unpack_busy         = busy;
  assign bus.o_dut_unpack_mode_err     = mode_err;

endmodule

// File: tb/tb_dut_unpack.sv
// -----------------------------------------------------------------------------
// tb_dut_unpack
// Purpose : self-checking bench for dut_unpack. Words to be offered sit in a
//           pending queue; every accepted word in a supported mode expands
//           into sixteen expected samples in a sample queue, and the front of
//           that queue is what the unpacker must be presenting. Frame position
//           is tracked as a count of completed words.
// -----------------------------------------------------------------------------
module tb_dut_unpack;

  localparam int W      = 16;
  localparam int N      = 16;
  localparam int WORD_W = W * N;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  dut_unpack_if #(.ADC_MAX_DATA_SIZE(W), .BRAM_WORD_NUM(N)) bus ();

  dut_unpack #(
    .ADC_MAX_DATA_SIZE(W),
    .BRAM_WORD_NUM    (N)
  ) u_dut (
    .i_dut_unpack_clk    (clk),
    .i_dut_unpack_reset_n(rst_n),
    .bus                 (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  logic [W-1:0]      q_data[$];
  logic [2:0]        q_chan[$];
  logic [WORD_W-1:0] pend_word[$];
  logic [2:0]        pend_mode[$];
  logic [15:0]       m_cnt;
  logic              m_err;

  // stimulus controls
  logic [15:0] f_len;
  int          ready_mode;
  bit          gappy;
  int          cyc;

  function automatic logic [W-1:0] expSample(input logic [W-1:0] s);
`ifdef DUT_UNPACK_BYTE_SWAP_EN
    return {s[7:0], s[15:8]};
`else
    return s;
`endif
  endfunction

  function automatic logic [WORD_W-1:0] randWord();
    logic [WORD_W-1:0] w;
    for (int i = 0; i < N; i++) w[i*W +: W] = W'($urandom);
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] rampWord();
    logic [WORD_W-1:0] w;
    for (int i = 0; i < N; i++) w[i*W +: W] = W'(i);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkOutput(input logic sr);
    logic exp_valid;
    logic exp_ready;
    logic exp_last;
    exp_valid = (q_data.size() != 0);
    exp_ready = (q_data.size() == 0) || ((q_data.size() == 1) && sr);
    chk("sample_valid", 32'(bus.o_dut_unpack_sample_valid), 32'(exp_valid));
    chk("word_ready",   32'(bus.o_dut_unpack_word_ready),   32'(exp_ready));
    chk("busy",         32'(bus.o_dut_unpack_busy),         32'(exp_valid));
    chk("mode_err",     32'(bus.o_dut_unpack_mode_err),     32'(m_err));
    if (exp_valid) begin
      exp_last = (q_data.size() == 1) && (f_len != 16'd0) && (m_cnt == f_len - 16'd1);
      chk("sample_data", 32'(bus.o_dut_unpack_sample_data), 32'(expSample(q_data[0])));
      chk("sample_chan", 32'(bus.o_dut_unpack_sample_chan), 32'(q_chan[0]));
      chk("sample_last", 32'(bus.o_dut_unpack_sample_last), 32'(exp_last));
    end
  endtask

  task automatic modelUpdate(input logic wv, input logic [WORD_W-1:0] wd,
                             input logic [2:0] md, input logic sr);
    logic exp_ready;
    logic consume;
    logic accept;
    exp_ready = (q_data.size() == 0) || ((q_data.size() == 1) && sr);
    consume   = (q_data.size() != 0) && sr;
    accept    = wv && exp_ready;
    if (consume) begin
      if (q_data.size() == 1) begin
        if ((f_len != 16'd0) && (m_cnt == f_len - 16'd1)) m_cnt = 16'd0;
        else m_cnt = m_cnt + 16'd1;
      end
      void'(q_data.pop_front());
      void'(q_chan.pop_front());
    end
    if (accept) begin
      void'(pend_word.pop_front());
      void'(pend_mode.pop_front());
      if (md == 3'b000 || md == 3'b011) begin
        for (int i = 0; i < N; i++) begin
          q_data.push_back(wd[i*W +: W]);
          q_chan.push_back((md == 3'b011) ? 3'(i) : 3'd0);
        end
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  // One clock cycle: drive at the low phase, check, then step the model at
  // the rising edge using the values that were presented.
  task automatic applyStimulus();
    logic              sr;
    logic              wv;
    logic [WORD_W-1:0] wd;
    logic [2:0]        md;
    case (ready_mode)
      0:       sr = 1'b1;
      1:       sr = (cyc % 2 == 0);
      default: sr = 1'($urandom_range(0, 1));
    endcase
    if (pend_word.size() != 0 && (!gappy || $urandom_range(0, 3) != 0)) begin
      wv = 1'b1;
      wd = pend_word[0];
      md = pend_mode[0];
    end else begin
      wv = 1'b0;
      wd = randWord();
      md = 3'($urandom_range(0, 7));
    end
    bus.i_dut_unpack_word_valid   = wv;
    bus.i_dut_unpack_word_data    = wd;
    bus.i_dut_unpack_capture_mode = md;
    bus.i_dut_unpack_sample_ready = sr;
    bus.i_dut_unpack_frame_len    = f_len;
    #1 checkOutput(sr);
    @(posedge clk);
    modelUpdate(wv, wd, md, sr);
    cyc++;
    @(negedge clk);
  endtask

  task automatic offerWord(input logic [WORD_W-1:0] w, input logic [2:0] md);
    pend_word.push_back(w);
    pend_mode.push_back(md);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (pend_word.size() == 0 && q_data.size() == 0) break;
      applyStimulus();
    end
    chk("drain_budget", 32'(pend_word.size() + q_data.size()), 32'd0);
    applyStimulus();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    bus.i_dut_unpack_word_valid   = 1'b0;
    bus.i_dut_unpack_sample_ready = 1'b0;
    #1;
    q_data.delete();
    q_chan.delete();
    pend_word.delete();
    pend_mode.delete();
    m_cnt = 16'd0;
    m_err = 1'b0;
    chk("rst_sample_valid", 32'(bus.o_dut_unpack_sample_valid), 32'd0);
    chk("rst_sample_data",  32'(bus.o_dut_unpack_sample_data),  32'd0);
    chk("rst_sample_chan",  32'(bus.o_dut_unpack_sample_chan),  32'd0);
    chk("rst_sample_last",  32'(bus.o_dut_unpack_sample_last),  32'd0);
    chk("rst_busy",         32'(bus.o_dut_unpack_busy),         32'd0);
    chk("rst_mode_err",     32'(bus.o_dut_unpack_mode_err),     32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_word_ready",   32'(bus.o_dut_unpack_word_ready),   32'd1);
    chk("rst_valid_after",  32'(bus.o_dut_unpack_sample_valid), 32'd0);
  endtask

  initial begin
    logic [WORD_W-1:0] w;
    rst_n      = 1'b1;
    f_len      = 16'd1;
    ready_mode = 0;
    gappy      = 1'b0;
    cyc        = 0;
    m_cnt      = 16'd0;
    m_err      = 1'b0;
    bus.i_dut_unpack_word_valid   = 1'b0;
    bus.i_dut_unpack_word_data    = '0;
    bus.i_dut_unpack_capture_mode = 3'b000;
    bus.i_dut_unpack_sample_ready = 1'b0;
    bus.i_dut_unpack_frame_len    = 16'd1;
    #2;

    $display("[TB] reset");
    doReset();

    $display("[TB] single-channel ramp word, frame_len 1");
    offerWord(rampWord(), 3'b000);
    drain(60);

    $display("[TB] lane 0 = 0x12AB byte order");
    w = randWord();
    w[W-1:0] = 16'h12AB;
    offerWord(w, 3'b000);
    drain(60);

    $display("[TB] octal mode, two words back-to-back");
    f_len = 16'd2;
    offerWord(randWord(), 3'b011);
    offerWord(randWord(), 3'b011);
    drain(80);

    $display("[TB] sample_ready toggling");
    ready_mode = 1;
    offerWord(randWord(), 3'b000);
    offerWord(randWord(), 3'b011);
    drain(120);
    ready_mode = 0;

    $display("[TB] unsupported mode then normal word");
    offerWord(randWord(), 3'b101);
    offerWord(randWord(), 3'b000);
    drain(60);

    $display("[TB] back-to-back load in unsupported mode");
    offerWord(randWord(), 3'b011);
    offerWord(randWord(), 3'b110);
    drain(60);

    $display("[TB] reset in mid-word");
    f_len = 16'd1;
    offerWord(randWord(), 3'b011);
    for (int i = 0; i < 40; i++) begin
      if (q_data.size() == N - 7) break;
      applyStimulus();
    end
    chk("mid_word_position", 32'(q_data.size()), 32'(N - 7));
    #2;
    doReset();
    offerWord(rampWord(), 3'b000);
    drain(60);

    $display("[TB] continuous stream, frame_len 0");
    f_len = 16'd0;
    for (int i = 0; i < 3; i++) offerWord(randWord(), 3'b011);
    drain(80);

    $display("[TB] randomized traffic");
    ready_mode = 2;
    gappy      = 1'b1;
    for (int b = 0; b < 5; b++) begin
      f_len = 16'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 9))
          0:       offerWord(randWord(), 3'($urandom_range(0, 7)));
          1, 2, 3, 4: offerWord(randWord(), 3'b011);
          default: offerWord(randWord(), 3'b000);
        endcase
      end
      drain(600);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
